// File: rtl/rob_pkg.sv
// Shared ROB/CDB types: tag, register and data widths, the CDB packet and the
// age helper used to order results relative to the ROB read pointer.
package rob_pkg;

  localparam int ROB_TAG_W = 5;
  localparam int PHY_W     = 6;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] robtag;
    logic [DATA_W-1:0]    data;
    logic [PHY_W-1:0]     phyaddr;
    logic                 regwrite;
  } cdb_pkt_t;

  // Distance from the ROB head; modular subtraction handles pointer wrap.
  function automatic logic [ROB_TAG_W-1:0] rob_age(input logic [ROB_TAG_W-1:0] tag,
                                                   input logic [ROB_TAG_W-1:0] rdptr);
    return tag - rdptr;
  endfunction

endpackage

// File: rtl/cdb_age_picker.sv
// Oldest-first selector, purely combinational (0 cycles); emits a one-hot grant
// for the valid entry with the smallest age, ties going to the lowest index.
module cdb_age_picker
  import rob_pkg::*;
#(
  parameter int N     = 4,
  parameter int AGE_W = ROB_TAG_W
) (
  input  logic [N-1:0]            valid,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant
);

  logic             found;
  logic [AGE_W-1:0] best_age;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    best_age = '0;
    // Strict less-than keeps the earlier (lower) index on equal ages.
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found || (age[i] < best_age))) begin
        grant    = '0;
        grant[i] = 1'b1;
        found    = 1'b1;
        best_age = age[i];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per requester, oldest result broadcast each cycle.
// Latency 2 edges req_val->cdb_val; req_rdy drops while a slot is full and not granted.
module cdb_arbiter
  import rob_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int ROB_DEPTH = 32,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_val,
  input  logic [NUM_REQ-1:0][ROB_TAG_W-1:0]  req_robtag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0][PHY_W-1:0]      req_phyaddr,
  input  logic [NUM_REQ-1:0]                 req_regwrite,
  output logic [NUM_REQ-1:0]                 req_rdy,
  input  logic [5:0]                         rob_rdptr,
  input  logic                               flush,
  input  logic [ROB_TAG_W-1:0]               flush_robtag,
  output logic                               cdb_val,
  output logic [ROB_TAG_W-1:0]               cdb_robtag,
  output logic [DATA_W-1:0]                  cdb_data,
  output logic [PHY_W-1:0]                   cdb_phyaddr,
  output logic                               cdb_regwrite,
  output logic [SRC_W-1:0]                   cdb_src
);

  if ($clog2(ROB_DEPTH) != ROB_TAG_W) begin : g_bad_depth
    $error("cdb_arbiter: ROB_DEPTH does not match ROB_TAG_W");
  end

  // The pointer's wrap bit is irrelevant to age ordering.
  logic                  unused_rdptr_msb;
  logic [ROB_TAG_W-1:0]  rdptr;
  assign unused_rdptr_msb = rob_rdptr[5];
  assign rdptr            = rob_rdptr[ROB_TAG_W-1:0];

  cdb_pkt_t                          hold_pkt [NUM_REQ];
  logic [NUM_REQ-1:0]                hold_vld;
  logic [NUM_REQ-1:0][ROB_TAG_W-1:0] hold_age;
  logic [NUM_REQ-1:0]                kill;
  logic [NUM_REQ-1:0]                cand;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_REQ-1:0]                accept;
  logic [ROB_TAG_W-1:0]              flush_age;
  cdb_pkt_t                          sel_pkt;
  logic [SRC_W-1:0]                  sel_src;

  assign flush_age = rob_age(flush_robtag, rdptr);

  always_comb begin
    hold_age = '0;
    kill     = '0;
    accept   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold_age[i] = rob_age(hold_pkt[i].robtag, rdptr);
      kill[i]     = flush & hold_vld[i] & (hold_age[i] > flush_age);
      // Incoming results younger than a mispredicted branch are discarded.
      accept[i]   = req_val[i] & req_rdy[i]
                  & ~(flush & (rob_age(req_robtag[i], rdptr) > flush_age));
    end
  end

  assign cand    = hold_vld & ~kill;
  assign req_rdy = ~hold_vld | grant;

  cdb_age_picker #(
    .N     (NUM_REQ),
    .AGE_W (ROB_TAG_W)
  ) u_picker (
    .valid (cand),
    .age   (hold_age),
    .grant (grant)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_vld[g] <= 1'b0;
      end else if (accept[g]) begin
        hold_vld[g] <= 1'b1;
      end else if (grant[g] || kill[g]) begin
        hold_vld[g] <= 1'b0;
      end
    end

    // Payload is qualified by hold_vld, so it needs no reset.
    always_ff @(posedge clk) begin
      if (accept[g]) begin
        hold_pkt[g] <= '{robtag:   req_robtag[g],
                         data:     req_data[g],
                         phyaddr:  req_phyaddr[g],
                         regwrite: req_regwrite[g]};
      end
    end
  end

  always_comb begin
    sel_pkt = '0;
    sel_src = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pkt = hold_pkt[i];
        sel_src = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_val      <= 1'b0;
      cdb_robtag   <= '0;
      cdb_data     <= '0;
      cdb_phyaddr  <= '0;
      cdb_regwrite <= 1'b0;
      cdb_src      <= '0;
    end else begin
      cdb_val <= |grant;
      if (|grant) begin
        cdb_robtag   <= sel_pkt.robtag;
        cdb_data     <= sel_pkt.data;
        cdb_phyaddr  <= sel_pkt.phyaddr;
        cdb_regwrite <= sel_pkt.regwrite;
        cdb_src      <= sel_src;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change and outputs are sampled on the
// falling edge, away from the rising edge the design acts on.
module tb_cdb_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_val;
  logic [3:0][4:0]  req_robtag;
  logic [3:0][31:0] req_data;
  logic [3:0][5:0]  req_phyaddr;
  logic [3:0]       req_regwrite;
  logic [3:0]       req_rdy;
  logic [5:0]       rob_rdptr;
  logic             flush;
  logic [4:0]       flush_robtag;
  logic             cdb_val;
  logic [4:0]       cdb_robtag;
  logic [31:0]      cdb_data;
  logic [5:0]       cdb_phyaddr;
  logic             cdb_regwrite;
  logic [1:0]       cdb_src;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter #(.NUM_REQ(4), .ROB_DEPTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_val      (req_val),
    .req_robtag   (req_robtag),
    .req_data     (req_data),
    .req_phyaddr  (req_phyaddr),
    .req_regwrite (req_regwrite),
    .req_rdy      (req_rdy),
    .rob_rdptr    (rob_rdptr),
    .flush        (flush),
    .flush_robtag (flush_robtag),
    .cdb_val      (cdb_val),
    .cdb_robtag   (cdb_robtag),
    .cdb_data     (cdb_data),
    .cdb_phyaddr  (cdb_phyaddr),
    .cdb_regwrite (cdb_regwrite),
    .cdb_src      (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int i, input logic [4:0] tag);
    req_val[i]      = 1'b1;
    req_robtag[i]   = tag;
    req_data[i]     = 32'hD000_0000 | 32'(tag);
    req_phyaddr[i]  = 6'(tag + 5'd1);
    req_regwrite[i] = tag[0];
  endtask

  task automatic idle();
    req_val = '0;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Registered broadcast observed at a falling edge.
  task automatic expect_bcast(input string tag, input logic [4:0] rt, input logic [1:0] src);
    check({tag, ".val"}, 32'(cdb_val), 32'd1);
    check({tag, ".tag"}, 32'(cdb_robtag), 32'(rt));
    check({tag, ".src"}, 32'(cdb_src), 32'(src));
    check({tag, ".data"}, cdb_data, 32'hD000_0000 | 32'(rt));
  endtask

  initial begin
    rst = 1'b1;
    req_val = '0; req_robtag = '0; req_data = '0; req_phyaddr = '0; req_regwrite = '0;
    rob_rdptr = '0; flush = 1'b0; flush_robtag = '0;

    #2;
    check("rst.cdb_val", 32'(cdb_val), 32'd0);
    check("rst.cdb_robtag", 32'(cdb_robtag), 32'd0);
    check("rst.cdb_data", cdb_data, 32'd0);
    check("rst.req_rdy", 32'(req_rdy), 32'hF);
    nedge(); nedge();
    rst = 1'b0;

    // Single request, two-edge latency, one-cycle pulse
    nedge(); drive(0, 5'd3);
    nedge(); idle();
    check("t1.lat1", 32'(cdb_val), 32'd0);
    nedge();
    expect_bcast("t1.b", 5'd3, 2'd0);
    check("t1.phy", 32'(cdb_phyaddr), 32'd4);
    check("t1.rw", 32'(cdb_regwrite), 32'd1);
    nedge();
    check("t1.pulse", 32'(cdb_val), 32'd0);
    check("t1.hold", 32'(cdb_robtag), 32'd3);

    // Age ordering across tag wrap
    rob_rdptr = 6'd30;
    drive(1, 5'd31); drive(2, 5'd1); drive(3, 5'd29);
    nedge(); idle();
    nedge(); expect_bcast("t2.first", 5'd31, 2'd1);
    nedge(); expect_bcast("t2.second", 5'd1, 2'd2);
    nedge(); expect_bcast("t2.third", 5'd29, 2'd3);
    nedge(); check("t2.done", 32'(cdb_val), 32'd0);

    // Flush kills younger slots and drops younger arrivals
    rob_rdptr = 6'd0;
    drive(0, 5'd5); drive(1, 5'd9); drive(2, 5'd12);
    nedge(); idle();
    flush = 1'b1; flush_robtag = 5'd9;
    drive(3, 5'd20);
    #1;
    check("t3.rdy_flush", 32'(req_rdy), 32'b1001);
    nedge(); flush = 1'b0; idle();
    expect_bcast("t3.b5", 5'd5, 2'd0);
    check("t3.rdy2", 32'(req_rdy[2]), 32'd1);
    nedge(); expect_bcast("t3.b9", 5'd9, 2'd1);
    nedge(); check("t3.no12", 32'(cdb_val), 32'd0);
    nedge(); check("t3.no20", 32'(cdb_val), 32'd0);

    // Older held result wins; streaming requester stalls then bursts
    drive(1, 5'd2); drive(0, 5'd4);
    nedge(); req_val[1] = 1'b0; drive(0, 5'd5);
    #1; check("t4.rdy0_low", 32'(req_rdy[0]), 32'd0);
    nedge(); expect_bcast("t4.b2", 5'd2, 2'd1);
    check("t4.rdy0_high", 32'(req_rdy[0]), 32'd1);
    nedge(); expect_bcast("t4.b4", 5'd4, 2'd0);
    drive(0, 5'd6);
    nedge(); expect_bcast("t4.b5", 5'd5, 2'd0);
    idle();
    nedge(); expect_bcast("t4.b6", 5'd6, 2'd0);
    nedge(); check("t4.done", 32'(cdb_val), 32'd0);

    // Reset between edges discards held packets immediately
    drive(0, 5'd7); drive(1, 5'd8);
    nedge(); idle();
    nedge(); expect_bcast("t5.pre", 5'd7, 2'd0);
    rst = 1'b1;
    #1;
    check("t5.val_now", 32'(cdb_val), 32'd0);
    check("t5.tag_now", 32'(cdb_robtag), 32'd0);
    check("t5.rdy_now", 32'(req_rdy), 32'hF);
    nedge(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nedge(); check($sformatf("t5.post%0d", k), 32'(cdb_val), 32'd0);
    end

    // Grant and accept on the same slot every cycle
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) expect_bcast($sformatf("t6.b%0d", k - 2), 5'(10 + k - 2), 2'd0);
      if (k < 6) begin
        drive(0, 5'(10 + k));
        #1; check($sformatf("t6.rdy%0d", k), 32'(req_rdy[0]), 32'd1);
      end else begin
        idle();
      end
      nedge();
    end
    check("t6.done", 32'(cdb_val), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
